// File: rtl/adder_rb_ctrl.sv
// adder_rb_ctrl: register bank and launch/wait sequencer for the adder IP.
// Decodes single-cycle AXI-side writes/reads into a five-word map, pulses
// the adder start, and waits for its done handshake under a watchdog.
module adder_rb_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic                    i_en_amba_write,
    input  logic [DATA_WIDTH-1:0]   i_data_wc,
    input  logic [31:0]             i_addr_wc,
    input  logic [3:0]              i_strb,
    input  logic [31:0]             i_addr_rc,
    output logic [DATA_WIDTH-1:0]   o_data_rc,
    output logic                    o_is_busy,
    output logic                    o_adder_start,
    output logic [DATA_WIDTH-1:0]   o_adder_op_a,
    output logic [DATA_WIDTH-1:0]   o_adder_op_b,
    input  logic                    i_adder_done,
    input  logic [DATA_WIDTH-1:0]   i_adder_result,
    input  logic                    i_adder_carry,
    output logic                    o_irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [5:0] IDX_OP_A   = 6'h00;
    localparam logic [5:0] IDX_OP_B   = 6'h01;
    localparam logic [5:0] IDX_CTRL   = 6'h02;
    localparam logic [5:0] IDX_STATUS = 6'h03;
    localparam logic [5:0] IDX_RESULT = 6'h04;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [7:0]              wd_cnt;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [DATA_WIDTH-1:0]   result;
    logic                    irq_en;
    logic                    done_flag;
    logic                    carry_flag;
    logic                    timeout_flag;
    logic                    start_q;
    logic                    irq_q;

    logic                    wr_ok;
    logic                    wr_op_a;
    logic                    wr_op_b;
    logic                    wr_ctrl;
    logic                    rd_map;
    logic [5:0]              rd_idx;

    // Byte-lane merge: strobed lanes take new data, others keep old value.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [3:0]            strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    // Writes land only while idle; anything strobed during a computation is dropped.
    assign wr_ok   = i_en_amba_write && (state == ST_IDLE) && (i_addr_wc[31:8] == 24'd0);
    assign wr_op_a = wr_ok && (i_addr_wc[7:2] == IDX_OP_A);
    assign wr_op_b = wr_ok && (i_addr_wc[7:2] == IDX_OP_B);
    assign wr_ctrl = wr_ok && (i_addr_wc[7:2] == IDX_CTRL) && i_strb[0];

    assign rd_map  = (i_addr_rc[31:8] == 24'd0);
    assign rd_idx  = i_addr_rc[7:2];

    // Byte-offset bits are don't-care for both ports.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr_wc[1:0], i_addr_rc[1:0]};

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
        o_data_rc = '0;
        if (rd_map) begin
            case (rd_idx)
                IDX_OP_A:   o_data_rc = op_a;
                IDX_OP_B:   o_data_rc = op_b;
                IDX_CTRL:   o_data_rc = {{(DATA_WIDTH-3){1'b0}}, 1'b0, irq_en, 1'b0};
                IDX_STATUS: o_data_rc = {{(DATA_WIDTH-4){1'b0}}, timeout_flag, carry_flag,
                                         done_flag, o_is_busy};
                IDX_RESULT: o_data_rc = result;
                default:    o_data_rc = '0;
            endcase
        end
    end

    // Sequencer FSM together with the register bank it guards.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state        <= ST_IDLE;
            wd_cnt       <= 8'd0;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            irq_en       <= 1'b0;
            done_flag    <= 1'b0;
            carry_flag   <= 1'b0;
            timeout_flag <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (wr_op_a) op_a <= lane_merge(op_a, i_data_wc, i_strb);
            if (wr_op_b) op_b <= lane_merge(op_b, i_data_wc, i_strb);
            case (state)
                ST_IDLE: begin
                    if (wr_ctrl) begin
                        irq_en <= i_data_wc[1];
                        if (i_data_wc[2]) begin
                            done_flag    <= 1'b0;
                            timeout_flag <= 1'b0;
                        end
                        if (i_data_wc[0]) begin
                            done_flag    <= 1'b0;
                            timeout_flag <= 1'b0;
                            carry_flag   <= 1'b0;
                            start_q      <= 1'b1;
                            state        <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    wd_cnt <= 8'd0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_adder_done) begin
                        result     <= i_adder_result;
                        carry_flag <= i_adder_carry;
                        done_flag  <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_flag <= 1'b1;
                        result       <= '0;
                        carry_flag   <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (wd_cnt != 8'hFF) begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Level interrupt, registered from the sticky completion flags.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) irq_q <= 1'b0;
        else                irq_q <= irq_en & (done_flag | timeout_flag);
    end

    assign o_is_busy     = (state != ST_IDLE);
    assign o_adder_start = start_q;
    assign o_adder_op_a  = op_a;
    assign o_adder_op_b  = op_b;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_adder_rb_ctrl.sv
// Directed bench for adder_rb_ctrl: hand-computed vectors, immediate assertions.
module tb_adder_rb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en_wr;
    logic [31:0] data_wc;
    logic [31:0] addr_wc;
    logic [3:0]  strb;
    logic [31:0] addr_rc;
    logic [31:0] data_rc;
    logic        busy;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        done;
    logic [31:0] result;
    logic        carry;
    logic        irq;

    int vectors = 0;
    int errors  = 0;
    int busy_cnt;
    int start_cnt;
    logic [31:0] rdata;

    adder_rb_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .i_en_amba_write(en_wr),
        .i_data_wc      (data_wc),
        .i_addr_wc      (addr_wc),
        .i_strb         (strb),
        .i_addr_rc      (addr_rc),
        .o_data_rc      (data_rc),
        .o_is_busy      (busy),
        .o_adder_start  (start),
        .o_adder_op_a   (op_a),
        .o_adder_op_b   (op_b),
        .i_adder_done   (done),
        .i_adder_result (result),
        .i_adder_carry  (carry),
        .o_irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        en_wr = 1'b1; addr_wc = a; data_wc = d; strb = s;
        tick();
        en_wr = 1'b0; strb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr_rc = a;
        #1;
        d = data_rc;
    endtask

    initial begin
        rst_n = 1'b0; en_wr = 1'b0; data_wc = '0; addr_wc = '0; strb = '0;
        addr_rc = '0; done = 1'b0; result = '0; carry = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        rd(32'h0C, rdata); check("rst_status", rdata, 32'd0);
        rd(32'h10, rdata); check("rst_result", rdata, 32'd0);

        // 5 + 7: done driven 3 cycles after the first WAIT cycle
        wr(32'h00, 32'h0000_0005, 4'hF);
        wr(32'h04, 32'h0000_0007, 4'hF);
        check("opb_port", op_b, 32'h7);
        wr(32'h08, 32'h1, 4'h1);
        busy_cnt = 0; start_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy) busy_cnt++;
            if (start) start_cnt++;
            if (k == 4) begin done = 1'b1; result = 32'h0000_000C; carry = 1'b0; end
            tick();
            done = 1'b0; result = 32'hFFFF_0000;
        end
        check("t1_busy_cycles", busy_cnt, 32'd5);
        check("t1_start_pulses", start_cnt, 32'd1);
        rd(32'h0C, rdata); check("t1_status", rdata, 32'h2);
        rd(32'h10, rdata); check("t1_result", rdata, 32'h0000_000C);
        check("t1_irq_disabled", {31'd0, irq}, 32'd0);

        // Byte-lane strobes on OP_A
        wr(32'h00, 32'h1122_3344, 4'hF);
        wr(32'h00, 32'hAABB_CCDD, 4'b0101);
        rd(32'h00, rdata); check("strb_op_a", rdata, 32'h11BB_33DD);
        check("strb_port", op_a, 32'h11BB_33DD);

        // Unmapped reads (0x100 would alias OP_A if upper bits were ignored)
        rd(32'h14, rdata); check("rd_0x14", rdata, 32'd0);
        rd(32'h100, rdata); check("rd_0x100", rdata, 32'd0);
        // Write to RO RESULT and to unmapped alias are ignored
        wr(32'h10, 32'h5555_5555, 4'hF);
        wr(32'h100, 32'h6666_6666, 4'hF);
        rd(32'h10, rdata); check("ro_result", rdata, 32'h0000_000C);
        rd(32'h00, rdata); check("alias_op_a", rdata, 32'h11BB_33DD);

        // Timeout with IRQ_EN
        wr(32'h08, 32'h3, 4'h1);
        busy_cnt = 0;
        for (int k = 0; k < 400 && busy; k++) begin
            busy_cnt++;
            tick();
        end
        check("to_busy_cycles", busy_cnt, 32'd256);
        rd(32'h0C, rdata); check("to_status", rdata, 32'h8);
        rd(32'h10, rdata); check("to_result", rdata, 32'h0);
        check("to_irq_first_idle", {31'd0, irq}, 32'd0);
        tick();
        check("to_irq_rise", {31'd0, irq}, 32'd1);
        wr(32'h08, 32'h6, 4'h1);
        check("irqclr_lag", {31'd0, irq}, 32'd1);
        rd(32'h0C, rdata); check("irqclr_status", rdata, 32'h0);
        tick();
        check("irqclr_irq", {31'd0, irq}, 32'd0);

        // Writes while busy are dropped
        wr(32'h08, 32'h1, 4'h1);
        check("t5_start", {31'd0, start}, 32'd1);
        tick();
        wr(32'h00, 32'hDEAD_BEEF, 4'hF);
        check("t5_start_a", {31'd0, start}, 32'd0);
        wr(32'h08, 32'h1, 4'h1);
        check("t5_start_b", {31'd0, start}, 32'd0);
        tick();
        check("t5_start_c", {31'd0, start}, 32'd0);
        done = 1'b1; result = 32'h1234_5678; carry = 1'b0;
        tick();
        done = 1'b0;
        check("t5_idle", {31'd0, busy}, 32'd0);
        rd(32'h00, rdata); check("t5_op_a", rdata, 32'h11BB_33DD);
        rd(32'h10, rdata); check("t5_result", rdata, 32'h1234_5678);

        // FFFFFFFF + 1, done in the very first WAIT cycle (minimum latency)
        wr(32'h00, 32'hFFFF_FFFF, 4'hF);
        wr(32'h04, 32'h0000_0001, 4'hF);
        wr(32'h08, 32'h1, 4'h1);
        check("t2_launch", {30'd0, busy, start}, 32'h3);
        tick();
        check("t2_wait", {30'd0, busy, start}, 32'h2);
        done = 1'b1; result = 32'h0; carry = 1'b1;
        tick();
        done = 1'b0; carry = 1'b0;
        check("t2_idle", {31'd0, busy}, 32'd0);
        rd(32'h10, rdata); check("t2_result", rdata, 32'h0);
        rd(32'h0C, rdata); check("t2_status", rdata, 32'h6);

        // Done while idle is ignored
        done = 1'b1; result = 32'hAAAA_AAAA;
        tick();
        done = 1'b0;
        rd(32'h10, rdata); check("idle_done_ignored", rdata, 32'h0);

        // Reset during WAIT
        wr(32'h08, 32'h3, 4'h1);
        tick();
        check("rw_in_wait", {30'd0, busy, start}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_start", {31'd0, start}, 32'd0);
        check("rw_op_a", op_a, 32'd0);
        check("rw_op_b", op_b, 32'd0);
        rd(32'h0C, rdata); check("rw_status", rdata, 32'd0);
        rd(32'h08, rdata); check("rw_ctrl", rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        start_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (start || busy || irq) start_cnt++;
        end
        check("rw_quiet_after", start_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
